uart_xfer_sched: RTL
====================

Name: uart_xfer_sched

Overview:
- Round-robin scheduler that shares one UART loopback datapath (clock generator + TX + RX) among NUM_REQ requesters.
- Each requester submits one byte plus its own line configuration. The scheduler programs the datapath, pulses start, waits for both done flags, and returns the received byte and error status to the granted requester.
- Sits between requester logic and the UART top on the system clock.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- SETUP_CYC, 8, clk cycles the configuration is held stable before start.
- START_HOLD, 32, clk cycles tx/rx start is held high; must exceed one baud-clock period.
- TIMEOUT, 1_000_000, clk cycles allowed in WAIT before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req  in  NUM_REQ  per-requester transfer request, level, held until its rsp_valid.
- req_data  in  NUM_REQ*8  byte per requester (slot i = bits 8i+7:8i).
- req_cfg  in  NUM_REQ*24  per requester {baud[16:0], length[3:0], parity_type, parity_en, stop2}.
- gnt  out  NUM_REQ  one-hot grant, held from ARB through RESP.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_data  out  8  received byte, valid with rsp_valid.
- rsp_status  out  3  {timeout, rx_err, tx_err}, valid with rsp_valid.
- u_tx_start, u_rx_start  out  1  start strobes to the UART.
- u_tx_data  out  8  byte to transmit.
- u_baud  out  17; u_length  out  4; u_parity_type, u_parity_en, u_stop2  out  1  UART configuration.
- u_tx_done, u_rx_done, u_tx_err, u_rx_err  in  1  UART status (baud-clock domain).
- u_rx_out  in  8  UART received byte.

Behaviour:
- Reset (rst low, async) drives all outputs to 0, FSM to IDLE, and the round-robin pointer to 0. Synchronizer flops clear.
- u_tx_done, u_rx_done, u_tx_err, u_rx_err each pass through a 2-flop synchronizer into clk. Done flags are rising-edge detected after synchronization.
- FSM IDLE: if any req bit is set, go to ARB next cycle.
- FSM ARB (1 cycle):
  - Grant the first set req at or after the pointer, wrapping.
  - Assert gnt. Latch that slot's data and cfg into output registers.
  - Set the pointer to granted+1 (mod NUM_REQ). Clear done/err capture flags. Go to SETUP.
- FSM SETUP: count SETUP_CYC cycles with config stable, then go to START.
- FSM START:
  - u_tx_start = u_rx_start = 1 for START_HOLD cycles.
  - Load the timeout counter. Go to WAIT.
- FSM WAIT:
  - Sticky-capture each done edge. Sticky-capture err flags while the corresponding done is seen.
  - When both dones are captured: latch u_rx_out (synchronized sample taken the cycle the rx_done edge is detected) and go to RESP.
  - If the counter reaches 0: go to RESP with timeout=1; rsp_data=0 if rx_done was not captured.
  - Done edges arriving during START are also captured; they may precede WAIT.
- FSM RESP (1 cycle): pulse rsp_valid[granted] with rsp_data/rsp_status. Drop gnt next cycle. Return to IDLE.
- The scheduler may grant the same requester again immediately after IDLE.
- Arbitration:
  - A req deasserted before grant is ignored.
  - req changes after grant do not affect the transfer in flight.
  - Simultaneous requests are resolved purely by the pointer.
- Configuration outputs (u_baud, u_length, etc.) hold their last values in IDLE. They change only in ARB.
- Reset mid-transfer: immediate return to IDLE, outputs 0, no rsp_valid.
- Latency with no contention: req to gnt = 2 cycles. Minimum total transfer = 2 + SETUP_CYC + START_HOLD + UART frame + sync delay + 1.

Decomposition:
- Package uart_sched_pkg:
  - state enum (IDLE, ARB, SETUP, START, WAIT, RESP).
  - cfg field widths and offsets (CFG_W=24).
  - status bit indices.
- Sub-module rr_arbiter (NUM_REQ param): combinational req + pointer -> one-hot grant and index.
- Synchronizers are instantiated inline.

Test Plan:
- Single requester 0, data 0xA5, baud 9600, length 8, no parity, 1 stop -> gnt=01 after 2 cycles; rsp_valid[0] pulse; rsp_data=0xA5; status=000.
- Both req held, data 0x11/0x22 -> grants alternate 01, 10, 01; responses 0x11, 0x22 in order; pointer wraps.
- Requester 1 with parity_en=1, odd parity, length 7, data 0x3C -> rsp_data=0x3C; status=000; u_length/u_parity outputs match cfg through the whole transfer.
- Done inputs tied low, TIMEOUT=200 -> rsp_valid after START_HOLD+200 (+/-1) cycles; status=100; rsp_data=0x00.
- Forced u_rx_err=1 with rx_done -> status=010; next transfer status=000 (flags cleared in ARB).
- rst low during WAIT -> all outputs 0 within the same cycle; no rsp_valid; after release, pending req is granted normally.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: FSM states, per-requester config field layout and response status bits
// shared by the UART transfer scheduler and its arbiter.
package uart_sched_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_SETUP, S_START, S_WAIT, S_RESP} state_e;
    localparam int CFG_W        = 24;
    localparam int BAUD_W       = 17;
    localparam int LEN_W        = 4;
    localparam int CFG_STOP2    = 0;
    localparam int CFG_PEN      = 1;
    localparam int CFG_PTYPE    = 2;
    localparam int CFG_LEN_LSB  = 3;
    localparam int CFG_BAUD_LSB = 7;
    localparam int ST_TX_ERR    = 0;
    localparam int ST_RX_ERR    = 1;
    localparam int ST_TIMEOUT   = 2;
    function automatic int wrap_idx(int base, int off, int n);
        return (base + off) % n;
    endfunction
endpackage

// File: rtl/uart_xfer_sched_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after the pointer, wrapping around.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               valid_o
);
    // Scan from the farthest slot back to the pointer so the nearest match wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[wrap_idx(int'(ptr_i), k, NUM_REQ)]) begin
                gnt_o   = '0;
                gnt_o[wrap_idx(int'(ptr_i), k, NUM_REQ)] = 1'b1;
                idx_o   = IW'(wrap_idx(int'(ptr_i), k, NUM_REQ));
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_xfer_sched.sv
// uart_xfer_sched: round-robin scheduler sharing one UART loopback datapath among
// NUM_REQ requesters; programs the UART, strobes start, and returns byte and status.
module uart_xfer_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int SETUP_CYC  = 8,
    parameter int START_HOLD = 32,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*8-1:0]     req_data,
    input  logic [NUM_REQ*CFG_W-1:0] req_cfg,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [7:0]               rsp_data,
    output logic [2:0]               rsp_status,
    output logic                     u_tx_start,
    output logic                     u_rx_start,
    output logic [7:0]               u_tx_data,
    output logic [BAUD_W-1:0]        u_baud,
    output logic [LEN_W-1:0]         u_length,
    output logic                     u_parity_type,
    output logic                     u_parity_en,
    output logic                     u_stop2,
    input  logic                     u_tx_done,
    input  logic                     u_rx_done,
    input  logic                     u_tx_err,
    input  logic                     u_rx_err,
    input  logic [7:0]               u_rx_out
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    state_e             state_q;
    logic [IW-1:0]      ptr_q, arb_idx;
    logic [NUM_REQ-1:0] gnt_q, rsp_valid_q, arb_gnt;
    logic               arb_valid, start_q;
    logic [7:0]         tx_data_q, rsp_data_q, rxs1_q, rxs2_q, rx_byte_q, rx_byte_d;
    logic [2:0]         rsp_status_q, status_d;
    logic [CFG_W-1:0]   cfg_q;
    logic [31:0]        cnt_q;
    logic [3:0]         sync1_q, sync2_q;
    logic [1:0]         done_prev_q, done_edge;
    logic               tx_seen_q, rx_seen_q, tx_err_q, rx_err_q;
    logic               tx_seen_d, rx_seen_d, tx_err_d, rx_err_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req_i(req), .ptr_i(ptr_q), .gnt_o(arb_gnt), .idx_o(arb_idx), .valid_o(arb_valid)
    );

    // sync bits: {rx_err, tx_err, rx_done, tx_done}; errors count only alongside their done edge
    assign done_edge = sync2_q[1:0] & ~done_prev_q;
    assign tx_seen_d = tx_seen_q | done_edge[0];
    assign rx_seen_d = rx_seen_q | done_edge[1];
    assign tx_err_d  = tx_err_q | (done_edge[0] & sync2_q[2]);
    assign rx_err_d  = rx_err_q | (done_edge[1] & sync2_q[3]);
    assign rx_byte_d = done_edge[1] ? rxs2_q : rx_byte_q;

    always_comb begin
        status_d             = '0;
        status_d[ST_TX_ERR]  = tx_err_d;
        status_d[ST_RX_ERR]  = rx_err_d;
        status_d[ST_TIMEOUT] = ~(tx_seen_d & rx_seen_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            start_q      <= 1'b0;
            tx_data_q    <= '0;
            cfg_q        <= '0;
            cnt_q        <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            done_prev_q  <= '0;
            rxs1_q       <= '0;
            rxs2_q       <= '0;
            rx_byte_q    <= '0;
            tx_seen_q    <= 1'b0;
            rx_seen_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            sync1_q     <= {u_rx_err, u_tx_err, u_rx_done, u_tx_done};
            sync2_q     <= sync1_q;
            done_prev_q <= sync2_q[1:0];
            rxs1_q      <= u_rx_out;
            rxs2_q      <= rxs1_q;
            rsp_valid_q <= '0;
            if (state_q == S_START || state_q == S_WAIT) begin
                tx_seen_q <= tx_seen_d;
                rx_seen_q <= rx_seen_d;
                tx_err_q  <= tx_err_d;
                rx_err_q  <= rx_err_d;
                rx_byte_q <= rx_byte_d;
            end
            case (state_q)
                S_IDLE: state_q <= (|req) ? S_ARB : S_IDLE;
                S_ARB: begin
                    state_q <= arb_valid ? S_SETUP : S_IDLE;
                    if (arb_valid) begin
                        gnt_q     <= arb_gnt;
                        tx_data_q <= req_data[8*arb_idx +: 8];
                        cfg_q     <= req_cfg[CFG_W*arb_idx +: CFG_W];
                        ptr_q     <= IW'(wrap_idx(int'(arb_idx), 1, NUM_REQ));
                        cnt_q     <= '0;
                        tx_seen_q <= 1'b0;
                        rx_seen_q <= 1'b0;
                        tx_err_q  <= 1'b0;
                        rx_err_q  <= 1'b0;
                        rx_byte_q <= '0;
                    end
                end
                S_SETUP: begin
                    cnt_q   <= (cnt_q == 32'(SETUP_CYC - 1)) ? '0 : cnt_q + 1;
                    start_q <= (cnt_q == 32'(SETUP_CYC - 1));
                    state_q <= (cnt_q == 32'(SETUP_CYC - 1)) ? S_START : S_SETUP;
                end
                S_START: begin
                    cnt_q   <= (cnt_q == 32'(START_HOLD - 1)) ? 32'(TIMEOUT) : cnt_q + 1;
                    start_q <= (cnt_q != 32'(START_HOLD - 1));
                    state_q <= (cnt_q == 32'(START_HOLD - 1)) ? S_WAIT : S_START;
                end
                S_WAIT: begin
                    if ((tx_seen_d && rx_seen_d) || cnt_q == '0) begin
                        state_q      <= S_RESP;
                        rsp_valid_q  <= gnt_q;
                        rsp_data_q   <= rx_seen_d ? rx_byte_d : 8'h00;
                        rsp_status_q <= status_d;
                    end else begin
                        cnt_q <= cnt_q - 1;
                    end
                end
                S_RESP: begin
                    gnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_status    = rsp_status_q;
    assign u_tx_start    = start_q;
    assign u_rx_start    = start_q;
    assign u_tx_data     = tx_data_q;
    assign u_baud        = cfg_q[CFG_BAUD_LSB +: BAUD_W];
    assign u_length      = cfg_q[CFG_LEN_LSB +: LEN_W];
    assign u_parity_type = cfg_q[CFG_PTYPE];
    assign u_parity_en   = cfg_q[CFG_PEN];
    assign u_stop2       = cfg_q[CFG_STOP2];
endmodule
